// File: rtl/quad_edge_raster_pkg.sv
// Shared constants, types and helpers for the quad outline rasterizer.
// The state encoding is also consumed by the frame-buffer writer's debug mux.
package quad_edge_raster_pkg;

    localparam int unsigned SCREEN_W  = 640;
    localparam int unsigned SCREEN_H  = 480;
    localparam int unsigned COORD_W   = 12;
    localparam int unsigned FRAC_BITS = 1;
    localparam int unsigned PIX_W     = COORD_W - FRAC_BITS;
    localparam int unsigned PX_W      = 10;
    localparam int unsigned PY_W      = 9;
    localparam int unsigned BODY_W    = 4;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STEP    = 2'd2,
        ST_DONE    = 2'd3
    } raster_state_e;

    typedef logic signed [PIX_W-1:0] pix_coord_t;

    typedef struct packed {
        pix_coord_t x;
        pix_coord_t y;
    } vertex_t;

    // Q10.1 to integer pixel: dropping the fraction bit is a floor shift.
    function automatic pix_coord_t q_to_pix(input logic signed [COORD_W-1:0] c);
        return c[COORD_W-1:FRAC_BITS];
    endfunction

    function automatic logic on_screen(input pix_coord_t x, input pix_coord_t y);
        return !x[PIX_W-1] && (x[PIX_W-2:0] < (PIX_W-1)'(SCREEN_W)) &&
               !y[PIX_W-1] && (y[PIX_W-2:0] < (PIX_W-1)'(SCREEN_H));
    endfunction

endpackage

// File: rtl/quad_edge_raster_if.sv
// Vertex input handshake plus pixel output port of the quad rasterizer.
interface quad_edge_raster_if;
    import quad_edge_raster_pkg::*;

    logic                      master_ready;
    logic                      slave_ready;
    logic signed [COORD_W-1:0] vertice_x;
    logic signed [COORD_W-1:0] vertice_y;
    logic [BODY_W-1:0]         nth_body;
    logic [1:0]                i_vertex;
    logic                      pix_valid;
    logic                      pix_ready;
    logic [PX_W-1:0]           pix_x;
    logic [PY_W-1:0]           pix_y;
    logic [BODY_W-1:0]         pix_body;
    logic                      quad_done;
    logic                      seq_err;

    modport slave (
        input  master_ready, vertice_x, vertice_y, nth_body, i_vertex, pix_ready,
        output slave_ready, pix_valid, pix_x, pix_y, pix_body, quad_done, seq_err
    );

    modport master (
        output master_ready, vertice_x, vertice_y, nth_body, i_vertex, pix_ready,
        input  slave_ready, pix_valid, pix_x, pix_y, pix_body, quad_done, seq_err
    );

endinterface

// File: rtl/quad_edge_raster_bresenham_stepper.sv
// Integer Bresenham walker for one edge. Exposes the position it will hold
// after this edge (x_c/y_c/at_end_c) so the caller can register its outputs.
module bresenham_stepper
    import quad_edge_raster_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       step_i,
    input  pix_coord_t x0_i,
    input  pix_coord_t y0_i,
    input  pix_coord_t x1_i,
    input  pix_coord_t y1_i,
    output pix_coord_t x_c,
    output pix_coord_t y_c,
    output logic       at_end_c,
    output logic       at_end_o
);

    localparam int unsigned DW    = PIX_W + 1;
    localparam int unsigned ERR_W = PIX_W + 2;
    localparam int unsigned E2_W  = PIX_W + 3;

    pix_coord_t               x_q, x_d, y_q, y_d, x1_q, x1_d, y1_q, y1_d;
    logic [DW-1:0]            dx_q, dx_d;
    logic signed [ERR_W-1:0]  dy_q, dy_d, err_q, err_d;
    logic signed [1:0]        sx_q, sx_d, sy_q, sy_d;
    logic                     at_end_q;

    logic signed [DW-1:0]     ddx_c, ddy_c;
    logic [DW-1:0]            adx_c, ady_c;
    logic signed [E2_W-1:0]   e2_c, dx_ext_c, dy_ext_c, err_sum_c;
    logic                     mv_x_c, mv_y_c;

    // Edge setup terms and one Bresenham advance; both branches use the old err.
    always_comb begin
        ddx_c     = {x1_i[PIX_W-1], x1_i} - {x0_i[PIX_W-1], x0_i};
        ddy_c     = {y1_i[PIX_W-1], y1_i} - {y0_i[PIX_W-1], y0_i};
        adx_c     = ddx_c[DW-1] ? DW'(-ddx_c) : DW'(ddx_c);
        ady_c     = ddy_c[DW-1] ? DW'(-ddy_c) : DW'(ddy_c);

        e2_c      = {err_q, 1'b0};
        dx_ext_c  = {2'b00, dx_q};
        dy_ext_c  = {dy_q[ERR_W-1], dy_q};
        mv_x_c    = (e2_c >= dy_ext_c);
        mv_y_c    = (e2_c <= dx_ext_c);
        err_sum_c = {err_q[ERR_W-1], err_q}
                  + (mv_x_c ? dy_ext_c : '0)
                  + (mv_y_c ? dx_ext_c : '0);

        x_d   = x_q;
        y_d   = y_q;
        x1_d  = x1_q;
        y1_d  = y1_q;
        dx_d  = dx_q;
        dy_d  = dy_q;
        err_d = err_q;
        sx_d  = sx_q;
        sy_d  = sy_q;

        if (load_i) begin
            x_d   = x0_i;
            y_d   = y0_i;
            x1_d  = x1_i;
            y1_d  = y1_i;
            dx_d  = adx_c;
            dy_d  = -$signed({1'b0, ady_c});
            err_d = {1'b0, adx_c} - {1'b0, ady_c};
            sx_d  = ddx_c[DW-1] ? 2'b11 : ((ddx_c != '0) ? 2'b01 : 2'b00);
            sy_d  = ddy_c[DW-1] ? 2'b11 : ((ddy_c != '0) ? 2'b01 : 2'b00);
        end else if (step_i) begin
            err_d = err_sum_c[ERR_W-1:0];
            if (mv_x_c) begin
                x_d = x_q + {{(PIX_W-2){sx_q[1]}}, sx_q};
            end
            if (mv_y_c) begin
                y_d = y_q + {{(PIX_W-2){sy_q[1]}}, sy_q};
            end
        end

        x_c      = x_d;
        y_c      = y_d;
        at_end_c = (x_d == x1_d) && (y_d == y1_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q      <= '0;
            y_q      <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
            at_end_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            at_end_q <= at_end_c;
        end
    end

    assign at_end_o = at_end_q;

endmodule

// File: rtl/quad_edge_raster.sv
// Collects four corner vertices per body, then draws the closed outline as
// four Bresenham edges, emitting one clipped pixel per cycle.
module quad_edge_raster
    import quad_edge_raster_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    quad_edge_raster_if.slave  bus
);

    raster_state_e     state_q, state_d;
    logic [1:0]        k_q, k_d, e_q, e_d, e_nxt_c;
    vertex_t           vbuf_q [4];
    vertex_t           vbuf_d [4];
    logic [BODY_W-1:0] body_q, body_d;
    logic              slave_ready_q, slave_ready_d;
    logic              pix_valid_q, pix_valid_d;
    logic [PX_W-1:0]   pix_x_q, pix_x_d;
    logic [PY_W-1:0]   pix_y_q, pix_y_d;
    logic              quad_done_q, quad_done_d;
    logic              seq_err_q, seq_err_d;

    logic              xfer_c, load_c, step_c;
    pix_coord_t        nxt_x_c, nxt_y_c;
    logic              nxt_end_c, at_end_q;
    vertex_t           in_vtx_c;

    bresenham_stepper u_stepper (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load_c),
        .step_i   (step_c),
        .x0_i     (vbuf_q[e_q].x),
        .y0_i     (vbuf_q[e_q].y),
        .x1_i     (vbuf_q[e_nxt_c].x),
        .y1_i     (vbuf_q[e_nxt_c].y),
        .x_c      (nxt_x_c),
        .y_c      (nxt_y_c),
        .at_end_c (nxt_end_c),
        .at_end_o (at_end_q)
    );

    assign e_nxt_c = e_q + 2'd1;

    // Next-state, buffer update and registered output decode.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        e_d       = e_q;
        vbuf_d    = vbuf_q;
        body_d    = body_q;
        seq_err_d = seq_err_q;
        load_c    = 1'b0;
        step_c    = 1'b0;
        xfer_c    = bus.master_ready && slave_ready_q;
        in_vtx_c  = '{x: q_to_pix(bus.vertice_x), y: q_to_pix(bus.vertice_y)};

        case (state_q)
            ST_COLLECT: begin
                if (xfer_c) begin
                    if (bus.i_vertex == k_q) begin
                        vbuf_d[k_q] = in_vtx_c;
                        if (k_q == 2'd0) begin
                            body_d = bus.nth_body;
                        end
                        k_d = k_q + 2'd1;
                        if (k_q == 2'd3) begin
                            state_d = ST_SETUP;
                            e_d     = 2'd0;
                        end
                    end else begin
                        seq_err_d = 1'b1;
                        if (bus.i_vertex == 2'd0) begin
                            vbuf_d[0] = in_vtx_c;
                            body_d    = bus.nth_body;
                            k_d       = 2'd1;
                        end else begin
                            k_d = 2'd0;
                        end
                    end
                end
            end
            ST_SETUP: begin
                load_c  = 1'b1;
                state_d = ST_STEP;
            end
            ST_STEP: begin
                if (at_end_q) begin
                    if (e_q == 2'd3) begin
                        state_d = ST_DONE;
                    end else begin
                        e_d     = e_nxt_c;
                        state_d = ST_SETUP;
                    end
                end else if (!pix_valid_q || bus.pix_ready) begin
                    // Off-screen points have no pix_valid and advance freely.
                    step_c = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_COLLECT;
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase

        slave_ready_d = (state_d == ST_COLLECT);
        quad_done_d   = (state_d == ST_DONE);
        pix_valid_d   = (state_d == ST_STEP) && !nxt_end_c && on_screen(nxt_x_c, nxt_y_c);
        pix_x_d       = pix_valid_d ? nxt_x_c[PX_W-1:0] : pix_x_q;
        pix_y_d       = pix_valid_d ? nxt_y_c[PY_W-1:0] : pix_y_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_COLLECT;
            k_q           <= '0;
            e_q           <= '0;
            body_q        <= '0;
            slave_ready_q <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            quad_done_q   <= 1'b0;
            seq_err_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                vbuf_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            e_q           <= e_d;
            body_q        <= body_d;
            slave_ready_q <= slave_ready_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            quad_done_q   <= quad_done_d;
            seq_err_q     <= seq_err_d;
            vbuf_q        <= vbuf_d;
        end
    end

    assign bus.slave_ready = slave_ready_q;
    assign bus.pix_valid   = pix_valid_q;
    assign bus.pix_x       = pix_x_q;
    assign bus.pix_y       = pix_y_q;
    assign bus.pix_body    = body_q;
    assign bus.quad_done   = quad_done_q;
    assign bus.seq_err     = seq_err_q;

endmodule

// File: tb/tb_quad_edge_raster.sv
// Directed bench for quad_edge_raster: expected pixels are queued as each quad
// is sent and popped by a negedge monitor as the DUT hands pixels over.
module tb_quad_edge_raster;
    import quad_edge_raster_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    quad_edge_raster_if bus ();

    quad_edge_raster dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [18:0] exp_q[$];
    int          exp_body = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          first_pv_cyc = -1;
    int          pv_cnt = 0;
    int          acc_cyc = 0;
    bit          bp_mode = 1'b0;
    bit          prev_stall = 1'b0;
    int          prev_x = 0;
    int          prev_y = 0;
    int          qx[4];
    int          qy[4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push_px(input int x, input int y);
        exp_q.push_back({10'(x), 9'(y)});
    endtask

    // Reference outline walk on plain integers.
    task automatic push_model();
        for (int e = 0; e < 4; e++) begin
            int x, y, x1, y1, dx, dy, sx, sy, err, e2, n;
            x  = qx[e] >>> 1;
            y  = qy[e] >>> 1;
            x1 = qx[(e + 1) % 4] >>> 1;
            y1 = qy[(e + 1) % 4] >>> 1;
            dx = (x1 > x) ? x1 - x : x - x1;
            dy = (y1 > y) ? y - y1 : y1 - y;
            sx = (x1 > x) ? 1 : ((x1 < x) ? -1 : 0);
            sy = (y1 > y) ? 1 : ((y1 < y) ? -1 : 0);
            err = dx + dy;
            n = 0;
            while (!(x == x1 && y == y1) && n < 5000) begin
                if (x >= 0 && x < 640 && y >= 0 && y < 480) push_px(x, y);
                e2 = 2 * err;
                if (e2 >= dy) begin err += dy; x += sx; end
                if (e2 <= dx) begin err += dx; y += sy; end
                n++;
            end
        end
    endtask

    task automatic send_vtx(input int body, input int idx, input int x, input int y);
        int n;
        n = 0;
        bus.master_ready = 1'b1;
        bus.nth_body     = 4'(body);
        bus.i_vertex     = 2'(idx);
        bus.vertice_x    = 12'(x);
        bus.vertice_y    = 12'(y);
        @(negedge clk);
        while (bus.slave_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("vtx_accept", int'(bus.slave_ready), 1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus.master_ready = 1'b0;
    endtask

    task automatic send_quad(input int body, input bit use_model,
                             input int x0, input int y0, input int x1, input int y1,
                             input int x2, input int y2, input int x3, input int y3);
        qx[0] = x0; qy[0] = y0; qx[1] = x1; qy[1] = y1;
        qx[2] = x2; qy[2] = y2; qx[3] = x3; qy[3] = y3;
        exp_body     = body;
        first_pv_cyc = -1;
        pv_cnt       = 0;
        if (use_model) push_model();
        for (int i = 0; i < 4; i++) send_vtx(body, i, qx[i], qy[i]);
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n, d0;
        n  = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_done_pulses"}, done_cnt - d0, 1);
        chk({tag, "_sb_left"}, exp_q.size(), 0);
    endtask

    // Pixel monitor: scoreboard pop on handshake, stall stability, done pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", int'(bus.pix_valid), 1);
                    chk("hold_x", int'(bus.pix_x), prev_x);
                    chk("hold_y", int'(bus.pix_y), prev_y);
                end
                if (bus.pix_valid === 1'b1) begin
                    pv_cnt++;
                    if (first_pv_cyc < 0) first_pv_cyc = cyc;
                    if (bus.pix_ready === 1'b1) begin
                        total++;
                        assert (exp_q.size() != 0) else begin
                            bad++;
                            $error("FAIL pix_unexpected observed=(%0d,%0d) expected=none",
                                   bus.pix_x, bus.pix_y);
                        end
                        if (exp_q.size() != 0) begin
                            logic [18:0] ev;
                            ev = exp_q.pop_front();
                            chk("pix_x", int'(bus.pix_x), int'(ev[18:9]));
                            chk("pix_y", int'(bus.pix_y), int'(ev[8:0]));
                            chk("pix_body", int'(bus.pix_body), exp_body);
                        end
                    end
                end
                prev_stall = (bus.pix_valid === 1'b1) && (bus.pix_ready !== 1'b1);
                prev_x     = int'(bus.pix_x);
                prev_y     = int'(bus.pix_y);
                if (bus.quad_done === 1'b1) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    // Frame-buffer ready: held high, or toggled every cycle in backpressure mode.
    initial begin
        bus.pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.pix_ready = bp_mode ? ~bus.pix_ready : 1'b1;
        end
    end

    initial begin
        bus.master_ready = 1'b0;
        bus.vertice_x    = '0;
        bus.vertice_y    = '0;
        bus.nth_body     = '0;
        bus.i_vertex     = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_slave_ready", int'(bus.slave_ready), 0);
        chk("rst_pix_valid", int'(bus.pix_valid), 0);
        chk("rst_quad_done", int'(bus.quad_done), 0);
        chk("rst_seq_err", int'(bus.seq_err), 0);
        chk("rst_pix_x", int'(bus.pix_x), 0);
        chk("rst_pix_y", int'(bus.pix_y), 0);
        chk("rst_pix_body", int'(bus.pix_body), 0);
        #1 rst = 1'b1;
        #1 chk("rel_slave_ready_before_edge", int'(bus.slave_ready), 0);
        @(posedge clk);
        #1 chk("rel_slave_ready_after_edge", int'(bus.slave_ready), 1);

        // Square outline, body 2
        push_px(100, 100); push_px(101, 100); push_px(102, 100); push_px(103, 100);
        push_px(103, 101); push_px(103, 102); push_px(103, 103); push_px(102, 103);
        push_px(101, 103); push_px(100, 103); push_px(100, 102); push_px(100, 101);
        send_quad(2, 1'b0, 200, 200, 206, 200, 206, 206, 200, 206);
        #1 chk("sq_slave_ready_low", int'(bus.slave_ready), 0);
        wait_done("square", 100);
        chk("square_pix_cycles", pv_cnt, 12);
        chk("square_first_pix_lat", first_pv_cyc - acc_cyc, 1);
        chk("square_done_lat", done_cyc - acc_cyc, 20);

        // Diagonal there and back under toggling backpressure
        bp_mode = 1'b1;
        push_px(0, 0); push_px(1, 1); push_px(2, 2); push_px(3, 3);
        push_px(4, 4); push_px(3, 3); push_px(2, 2); push_px(1, 1);
        send_quad(4, 1'b0, 0, 0, 8, 8, 8, 8, 0, 0);
        wait_done("diag", 200);
        bp_mode = 1'b0;
        @(posedge clk);

        // Left-edge clipping
        push_px(0, 5); push_px(1, 5); push_px(2, 5); push_px(1, 5); push_px(0, 5);
        send_quad(5, 1'b0, -4, 10, 4, 10, 4, 10, -4, 10);
        wait_done("clip", 100);
        chk("clip_pix_cycles", pv_cnt, 5);

        // Out-of-order corners, then a restart at corner 0, then a clean quad
        send_vtx(1, 0, 10, 10);
        send_vtx(1, 1, 12, 10);
        send_vtx(1, 3, 12, 12);
        chk("seq_err_set", int'(bus.seq_err), 1);
        chk("seq_err_still_collect", int'(bus.slave_ready), 1);
        send_vtx(9, 0, 300, 300);
        send_vtx(9, 1, 310, 300);
        send_quad(7, 1'b1, 20, 30, 61, 30, 61, 47, 20, 47);
        wait_done("seq", 200);
        chk("seq_err_sticky", int'(bus.seq_err), 1);

        // Fully degenerate quad
        send_quad(6, 1'b0, 100, 100, 100, 100, 100, 100, 100, 100);
        wait_done("degen", 50);
        chk("degen_pix_cycles", pv_cnt, 0);
        chk("degen_done_cycle", done_cyc - acc_cyc + 1, 9);

        // Reset in the middle of a long edge
        send_quad(3, 1'b1, 0, 0, 400, 0, 400, 400, 0, 400);
        repeat (15) @(negedge clk);
        chk("pre_rst_drawing", int'(bus.pix_valid), 1);
        @(posedge clk);
        #2 rst = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_pix_valid", int'(bus.pix_valid), 0);
        chk("mid_rst_slave_ready", int'(bus.slave_ready), 0);
        chk("mid_rst_seq_err", int'(bus.seq_err), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("post_rst_ready_before_edge", int'(bus.slave_ready), 0);
        @(posedge clk);
        #1 chk("post_rst_ready_after_edge", int'(bus.slave_ready), 1);

        // Fresh quad straddling the right and bottom screen borders
        send_quad(11, 1'b1, 1270, 950, 1290, 950, 1290, 970, 1270, 970);
        wait_done("post_rst", 200);
        chk("post_rst_pix_body", int'(bus.pix_body), 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
